// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that assembles little-endian words from a byte stream into instruction memory.
// Latency: 4 accepted bytes + 1 WRITE cycle per word; RUN (CPU released) the cycle after the last write.
// Backpressure: in_ready low during WRITE and RUN; in_valid gaps stall assembly with partial state preserved.
module imem_loader #(
  parameter int WORD  = 32,
  parameter int DEPTH = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  input  logic             reload,
  output logic             imem_we,
  output logic [WORD-1:0]  imem_addr,
  output logic [WORD-1:0]  imem_wdata,
  output logic             cpu_rst,
  output logic             done,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [1:0] {HEADER, LOAD, WRITE, RUN} state_t;

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] numWords;
  logic [CNT_W-1:0] wordIdx;
  logic [CNT_W-1:0] wordIdxInc;
  logic [CNT_W-1:0] wordCnt;
  logic [CNT_W-1:0] hdrClamp;
  logic [1:0]       byteIdx;
  logic [WORD-1:0]  asmWord;
  logic [WORD-1:0]  addrReg;
  logic [WORD-1:0]  wdataReg;
  logic             accept;

  assign accept     = in_valid & in_ready;
  assign wordIdxInc = wordIdx + CNT_W'(1);
  // Header counts above capacity are clamped so the address can never wrap.
  assign hdrClamp   = (int'(in_byte) > DEPTH) ? CNT_W'(DEPTH) : CNT_W'(in_byte);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HEADER;
    else      state <= stateNext;
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      HEADER: if (accept) stateNext = (hdrClamp == '0) ? RUN : LOAD;
      LOAD:   if (accept && byteIdx == 2'd3) stateNext = WRITE;
      WRITE:  stateNext = (wordIdxInc == numWords) ? RUN : LOAD;
      RUN:    if (reload) stateNext = HEADER;
      default: stateNext = HEADER;
    endcase
  end

  // Control outputs decoded from the state register only (glitch-free CPU reset).
  always_comb begin
    in_ready = rst & ((state == HEADER) | (state == LOAD));
    imem_we  = (state == WRITE);
    cpu_rst  = (state != RUN);
    done     = (state == RUN);
  end

  // Datapath: header capture, byte assembly, write address/data staging, counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      numWords <= '0;
      wordIdx  <= '0;
      wordCnt  <= '0;
      byteIdx  <= '0;
      asmWord  <= '0;
      addrReg  <= '0;
      wdataReg <= '0;
    end else begin
      case (state)
        HEADER: begin
          if (accept) begin
            numWords <= hdrClamp;
            wordIdx  <= '0;
            byteIdx  <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            asmWord[{byteIdx, 3'b000} +: 8] <= in_byte;
            byteIdx <= byteIdx + 2'd1;
            // Stage the write so addr/data are stable registers during WRITE and hold afterwards.
            if (byteIdx == 2'd3) begin
              addrReg  <= WORD'(wordIdx) << 2;
              wdataReg <= {in_byte, asmWord[23:0]};
            end
          end
        end
        WRITE: begin
          wordIdx <= wordIdxInc;
          wordCnt <= wordCnt + CNT_W'(1);
          byteIdx <= '0;
        end
        RUN: begin
          if (reload) begin
            wordCnt <= '0;
            wordIdx <= '0;
            byteIdx <= '0;
            asmWord <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = addrReg;
  assign imem_wdata = wdataReg;
  assign word_count = wordCnt;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives table-driven and randomized byte streams into imem_loader.
// Expected writes come from a simple model: word i = bytes 4i..4i+3 little-endian at address 4i.
// Hand sequences cover reset values, reload handshake, and reset mid-load.
module tb_imem_loader;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        reload = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic [7:0]  word_count;

  imem_loader #(.WORD(32), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];
  logic [7:0]  presetQ[$];
  logic [7:0]  sentQ[$];

  typedef struct {
    string    name;
    logic [7:0] hdr;
    bit       gaps;
    int       expCnt;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Write monitor: records every write strobe; loader must not accept bytes while writing.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wrAddrQ.push_back(imem_addr);
      wrDataQ.push_back(imem_wdata);
      check("ready_in_write", {31'b0, in_ready}, 32'd0);
    end
  end

  // Offer one byte (optionally after random idle cycles) and return once it is accepted.
  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int guard;
    int g;
    guard = 0;
    if (gaps) begin
      g = $urandom_range(0, 3);
      repeat (g) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    while (in_ready !== 1'b1) begin
      guard++;
      if (guard > 50) begin
        check("ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // After the header: stream 4*expCnt bytes, then check timing, final state and writes.
  task automatic finishLoad(input string nm, input int expCnt, input bit gaps);
    logic [7:0]  b;
    logic [31:0] expData;
    sentQ.delete();
    if (expCnt == 0) begin
      @(negedge clk);
      check({nm, "_zero_done"}, {31'b0, done}, 32'd1);
    end else begin
      for (int i = 0; i < 4 * expCnt; i++) begin
        if (presetQ.size() > 0) b = presetQ.pop_front();
        else                    b = 8'($urandom);
        sentQ.push_back(b);
        sendByte(b, gaps);
      end
      @(negedge clk);
      check({nm, "_last_we"}, {31'b0, imem_we}, 32'd1);
      @(negedge clk);
      check({nm, "_done"}, {31'b0, done}, 32'd1);
    end
    check({nm, "_cpu_rst"}, {31'b0, cpu_rst}, 32'd0);
    check({nm, "_word_count"}, {24'b0, word_count}, 32'(expCnt));
    // Extra bytes beyond the load must not be consumed.
    in_valid = 1'b1;
    in_byte  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      check({nm, "_ready_after"}, {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    check({nm, "_nwrites"}, 32'(wrAddrQ.size()), 32'(expCnt));
    for (int i = 0; i < expCnt && i < wrAddrQ.size(); i++) begin
      expData = {sentQ[4*i+3], sentQ[4*i+2], sentQ[4*i+1], sentQ[4*i]};
      check({nm, "_addr"}, wrAddrQ[i], 32'(4 * i));
      check({nm, "_data"}, wrDataQ[i], expData);
    end
  endtask

  task automatic runLoad(input string nm, input logic [7:0] hdr, input bit gaps, input int expCnt);
    wrAddrQ.delete();
    wrDataQ.delete();
    sendByte(hdr, gaps);
    finishLoad(nm, expCnt, gaps);
  endtask

  task automatic doReload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
    @(negedge clk);
    check("reload_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("reload_done", {31'b0, done}, 32'd0);
    check("reload_word_count", {24'b0, word_count}, 32'd0);
    check("reload_ready", {31'b0, in_ready}, 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"two_gap",  8'd2,   1'b1, 2};
    vecs[1] = '{"zero",     8'd0,   1'b0, 0};
    vecs[2] = '{"clamp_ff", 8'hFF,  1'b0, 64};
    vecs[3] = '{"one_gap",  8'd1,   1'b1, 1};
    vecs[4] = '{"exact64",  8'd64,  1'b1, 64};
    vecs[5] = '{"clamp65",  8'd65,  1'b0, 64};
    vecs[6] = '{"three",    8'd3,   1'b1, 3};

    // Reset values held with in_valid asserted.
    rst = 1'b0;
    in_valid = 1'b1;
    in_byte = 8'h05;
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", {31'b0, in_ready}, 32'd0);
      check("rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_we", {31'b0, imem_we}, 32'd0);
      check("rst_word_count", {24'b0, word_count}, 32'd0);
    end
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1 check("release_ready", {31'b0, in_ready}, 32'd1);

    // Two-word load, back to back, with known data.
    presetQ = '{8'h20, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    runLoad("two_word", 8'h02, 1'b0, 2);
    if (wrDataQ.size() == 2) begin
      check("two_word_d0", wrDataQ[0], 32'h00010020);
      check("two_word_d1", wrDataQ[1], 32'h12345678);
      check("two_word_a1", wrAddrQ[1], 32'h4);
    end

    // Table-driven loads with randomized data.
    foreach (vecs[i]) begin
      doReload();
      runLoad(vecs[i].name, vecs[i].hdr, vecs[i].gaps, vecs[i].expCnt);
    end

    // Reload with in_valid high in the same cycle: byte must not be taken in RUN.
    @(negedge clk);
    reload = 1'b1;
    in_valid = 1'b1;
    in_byte = 8'h01;
    check("simul_ready_run", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1 reload = 1'b0;
    @(negedge clk);
    check("simul_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("simul_ready", {31'b0, in_ready}, 32'd1);
    check("simul_wc", {24'b0, word_count}, 32'd0);
    wrAddrQ.delete();
    wrDataQ.delete();
    @(posedge clk);
    #1 in_valid = 1'b0;
    presetQ = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    finishLoad("simul", 1, 1'b0);
    if (wrDataQ.size() == 1) check("simul_d0", wrDataQ[0], 32'hDEADBEEF);

    // Reset mid-load: after word 0 written and two bytes of word 1.
    doReload();
    sendByte(8'h02, 1'b0);
    for (int i = 0; i < 6; i++) sendByte(8'(i + 1), 1'b0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, in_ready}, 32'd0);
    check("mid_rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_we", {31'b0, imem_we}, 32'd0);
    check("mid_rst_wc", {24'b0, word_count}, 32'd0);
    check("mid_rst_addr", imem_addr, 32'd0);
    check("mid_rst_wdata", imem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    presetQ = '{8'h44, 8'h33, 8'h22, 8'h11};
    runLoad("after_rst", 8'h01, 1'b0, 1);
    if (wrDataQ.size() == 1) check("after_rst_d0", wrDataQ[0], 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
